// File: rtl/ofs_fim_pcie_ats_tx_arb.sv
// Packet-atomic TX arbiter merging multi-beat AFU TLPs with single-beat ATS
// invalidation completion headers queued in an internal FIFO.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   afu_t*              AFU TX stream in (valid/ready, data/keep/user/last)
//   cpl_valid/ready/hdr completion header push into the FIFO
//   tx_t*               merged FIM-to-host TX stream out (1-cycle latency)
//   cpl_fifo_cnt        current FIFO occupancy
//   stat_cpl_cnt        completions issued       (OFS_FIM_ATS_TX_ARB_STATS_EN)
//   stat_fifo_hwm       FIFO high-water mark     (OFS_FIM_ATS_TX_ARB_STATS_EN)
module ofs_fim_pcie_ats_tx_arb #(
    parameter int TDATA_WIDTH    = 512,
    parameter int TUSER_WIDTH    = 10,
    parameter int CPL_FIFO_DEPTH = 8,
    parameter int CPL_BURST      = 1,
    localparam int AW            = $clog2(CPL_FIFO_DEPTH),
    localparam int CW            = AW + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     afu_tvalid,
    output logic                     afu_tready,
    input  logic [TDATA_WIDTH-1:0]   afu_tdata,
    input  logic [TDATA_WIDTH/8-1:0] afu_tkeep,
    input  logic [TUSER_WIDTH-1:0]   afu_tuser,
    input  logic                     afu_tlast,
    input  logic                     cpl_valid,
    output logic                     cpl_ready,
    input  logic [255:0]             cpl_hdr,
    output logic                     tx_tvalid,
    input  logic                     tx_tready,
    output logic [TDATA_WIDTH-1:0]   tx_tdata,
    output logic [TDATA_WIDTH/8-1:0] tx_tkeep,
    output logic [TUSER_WIDTH-1:0]   tx_tuser,
    output logic                     tx_tlast,
    output logic [CW-1:0]            cpl_fifo_cnt,
    output logic [31:0]              stat_cpl_cnt,
    output logic [CW-1:0]            stat_fifo_hwm
);

    localparam int RW = $clog2(CPL_BURST + 1);

    typedef enum logic {
        PRIO_AFU = 1'b0,
        PRIO_CPL = 1'b1
    } prio_t;

    logic [255:0]  mem [CPL_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    logic          in_pkt;
    prio_t         prio;
    logic [RW-1:0] cpl_run;
    logic [RW-1:0] run_inc;

    logic          adv;
    logic          push;
    logic          sel_cpl;
    logic          afu_fire;

    // Ready depends on registered occupancy only: a same-cycle pop
    // never opens a full FIFO.
    assign cpl_ready    = cnt < CW'(CPL_FIFO_DEPTH);
    assign cpl_fifo_cnt = cnt;
    assign push         = cpl_valid && cpl_ready;

    assign adv     = !tx_tvalid || tx_tready;
    assign sel_cpl = adv && !in_pkt && (cnt != '0)
                   && (prio == PRIO_CPL || !afu_tvalid);

    // Mid-packet the AFU owns the output; otherwise it must win arbitration.
    assign afu_tready = adv && (in_pkt || (!sel_cpl && afu_tvalid));
    assign afu_fire   = afu_tvalid && afu_tready;

    assign run_inc = cpl_run + RW'(1);

    always_comb begin
        cnt_next = cnt;
        if (push && !sel_cpl) begin
            cnt_next = cnt + CW'(1);
        end else if (sel_cpl && !push) begin
            cnt_next = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cpl_hdr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_tvalid <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            in_pkt    <= 1'b0;
            prio      <= PRIO_CPL;
            cpl_run   <= '0;
        end else begin
            cnt <= cnt_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (sel_cpl) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (adv) begin
                tx_tvalid <= sel_cpl || afu_fire;
            end
            // Hand the turn to the AFU once the burst is used up or
            // the queue has drained.
            if (sel_cpl) begin
                if (run_inc == RW'(CPL_BURST) || cnt_next == '0) begin
                    prio    <= PRIO_AFU;
                    cpl_run <= '0;
                end else begin
                    cpl_run <= run_inc;
                end
            end
            if (afu_fire) begin
                in_pkt <= !afu_tlast;
                if (afu_tlast) begin
                    prio <= PRIO_CPL;
                end
            end
        end
    end

    // Payload is don't-care while tx_tvalid is low, so no reset needed.
    always_ff @(posedge clk) begin
        if (adv) begin
            if (sel_cpl) begin
                tx_tdata <= TDATA_WIDTH'(mem[rd_ptr]);
                tx_tkeep <= (TDATA_WIDTH/8)'(32'hFFFF_FFFF);
                tx_tuser <= '0;
                tx_tlast <= 1'b1;
            end else begin
                tx_tdata <= afu_tdata;
                tx_tkeep <= afu_tkeep;
                tx_tuser <= afu_tuser;
                tx_tlast <= afu_tlast;
            end
        end
    end

`ifdef OFS_FIM_ATS_TX_ARB_STATS_EN
    logic [31:0]   cpl_cnt_q;
    logic [CW-1:0] hwm_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpl_cnt_q <= '0;
            hwm_q     <= '0;
        end else begin
            if (sel_cpl) begin
                cpl_cnt_q <= cpl_cnt_q + 32'd1;
            end
            if (cnt_next > hwm_q) begin
                hwm_q <= cnt_next;
            end
        end
    end

    assign stat_cpl_cnt  = cpl_cnt_q;
    assign stat_fifo_hwm = hwm_q;
`else
    assign stat_cpl_cnt  = '0;
    assign stat_fifo_hwm = '0;
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ats_tx_arb.sv
// Self-checking bench for ofs_fim_pcie_ats_tx_arb.
// Ordered scoreboard of expected TX beats plus a FIFO fill/drain vector table.
module tb_ofs_fim_pcie_ats_tx_arb;

    localparam int TDW = 512;
    localparam int TUW = 10;
    localparam int D   = 8;
    localparam int CW  = $clog2(D) + 1;
    localparam int TO  = 200;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             afu_tvalid;
    logic             afu_tready;
    logic [TDW-1:0]   afu_tdata;
    logic [TDW/8-1:0] afu_tkeep;
    logic [TUW-1:0]   afu_tuser;
    logic             afu_tlast;
    logic             cpl_valid;
    logic             cpl_ready;
    logic [255:0]     cpl_hdr;
    logic             tx_tvalid;
    logic             tx_tready;
    logic [TDW-1:0]   tx_tdata;
    logic [TDW/8-1:0] tx_tkeep;
    logic [TUW-1:0]   tx_tuser;
    logic             tx_tlast;
    logic [CW-1:0]    cpl_fifo_cnt;
    logic [31:0]      stat_cpl_cnt;
    logic [CW-1:0]    stat_fifo_hwm;

    ofs_fim_pcie_ats_tx_arb #(
        .TDATA_WIDTH(TDW),
        .TUSER_WIDTH(TUW),
        .CPL_FIFO_DEPTH(D),
        .CPL_BURST(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .afu_tvalid(afu_tvalid),
        .afu_tready(afu_tready),
        .afu_tdata(afu_tdata),
        .afu_tkeep(afu_tkeep),
        .afu_tuser(afu_tuser),
        .afu_tlast(afu_tlast),
        .cpl_valid(cpl_valid),
        .cpl_ready(cpl_ready),
        .cpl_hdr(cpl_hdr),
        .tx_tvalid(tx_tvalid),
        .tx_tready(tx_tready),
        .tx_tdata(tx_tdata),
        .tx_tkeep(tx_tkeep),
        .tx_tuser(tx_tuser),
        .tx_tlast(tx_tlast),
        .cpl_fifo_cnt(cpl_fifo_cnt),
        .stat_cpl_cnt(stat_cpl_cnt),
        .stat_fifo_hwm(stat_fifo_hwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TDW-1:0]   d;
        logic [TDW/8-1:0] k;
        logic [TUW-1:0]   u;
        logic             l;
    } beat_t;

    typedef struct {
        logic v;
        logic r;
        int   cnt;
        logic crdy;
    } vec_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic logic [255:0] mk_hdr(input int n);
        logic [255:0] h;
        h = '0;
        h[255:224] = 32'hA75A_0000 | 32'(n);
        h[7:0]     = 8'h02;
        h[15:8]    = 8'(n);
        return h;
    endfunction

    function automatic logic [TDW-1:0] afu_d(input int id, input int b);
        logic [TDW-1:0] d;
        d = '0;
        d[TDW-1 -: 32] = {16'hAF00, 8'(id), 8'(b)};
        d[15:0]        = {8'(id), 8'(b)};
        return d;
    endfunction

    function automatic logic [TDW/8-1:0] afu_k(input logic last);
        logic [TDW/8-1:0] k;
        k = '1;
        if (last) k[TDW/8-1 -: 8] = 8'h00;
        return k;
    endfunction

    task automatic push_afu(input int id, input int n);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            e.d = afu_d(id, b);
            e.k = afu_k(b == n - 1);
            e.u = TUW'(id);
            e.l = (b == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_cpl(input int n);
        beat_t e;
        e.d = '0;
        e.d[255:0] = mk_hdr(n);
        e.k = '0;
        e.k[31:0] = '1;
        e.u = '0;
        e.l = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s timeout", name);
    endtask

    // Output monitor: in-order scoreboard and hold-while-stalled check.
    beat_t hold;
    logic  held = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                n_cmp++;
                if (tx_tvalid !== 1'b1 || tx_tdata !== hold.d ||
                    tx_tkeep !== hold.k || tx_tuser !== hold.u ||
                    tx_tlast !== hold.l) begin
                    n_bad++;
                    $display("FAIL stall_hold act=%h exp=%h",
                             tx_tdata[31:0], hold.d[31:0]);
                end
            end
            if (tx_tvalid && tx_tready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat_extra act=%h u=%h",
                             tx_tdata, tx_tuser);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_tdata !== e.d || tx_tkeep !== e.k ||
                        tx_tuser !== e.u || tx_tlast !== e.l) begin
                        n_bad++;
                        $display("FAIL beat act d=%h k=%h u=%h l=%b exp d=%h k=%h u=%h l=%b",
                                 tx_tdata, tx_tkeep, tx_tuser, tx_tlast,
                                 e.d, e.k, e.u, e.l);
                    end
                end
            end
            held   = tx_tvalid && !tx_tready;
            hold.d = tx_tdata;
            hold.k = tx_tkeep;
            hold.u = tx_tuser;
            hold.l = tx_tlast;
        end
    end

    task automatic send_pkt(input int id, input int n);
        int t;
        for (int b = 0; b < n; b++) begin
            afu_tvalid = 1'b1;
            afu_tdata  = afu_d(id, b);
            afu_tkeep  = afu_k(b == n - 1);
            afu_tuser  = TUW'(id);
            afu_tlast  = (b == n - 1);
            t = 0;
            @(negedge clk);
            while (!afu_tready && t < TO) begin
                @(negedge clk);
                t++;
            end
            if (t >= TO) begin
                timeout_fail("afu_beat");
                afu_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        afu_tvalid = 1'b0;
    endtask

    task automatic cpl_push(input int n);
        int t;
        cpl_valid = 1'b1;
        cpl_hdr   = mk_hdr(n);
        t = 0;
        @(negedge clk);
        while (!cpl_ready && t < TO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TO) timeout_fail("cpl_push");
        @(posedge clk);
        #1;
        cpl_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || tx_tvalid) && t < TO) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= TO) begin
            n_bad++;
            $display("FAIL drain left=%0d", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        afu_tvalid = 1'b0;
        cpl_valid  = 1'b0;
        tx_tready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(tx_tvalid), 64'd0);
        chk("rst_cnt", 64'(cpl_fifo_cnt), 64'd0);
        chk("rst_cpl_ready", 64'(cpl_ready), 64'd1);
        chk("rst_stat_cnt", 64'(stat_cpl_cnt), 64'd0);
        chk("rst_stat_hwm", 64'(stat_fifo_hwm), 64'd0);
        rst_n = 1'b1;
    endtask

    vec_t tbl[19];
    int   cnt_tab[19] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8,
                          7, 7, 6, 5, 4, 3, 2, 1, 0};

    initial begin
        int idx;
        logic acc;
        rst_n      = 1'b0;
        afu_tvalid = 1'b0;
        afu_tdata  = '0;
        afu_tkeep  = '0;
        afu_tuser  = '0;
        afu_tlast  = 1'b0;
        cpl_valid  = 1'b0;
        cpl_hdr    = '0;
        tx_tready  = 1'b1;

        // Fill to full with TX stalled, hold a push while full, then drain.
        for (int i = 0; i < 19; i++) begin
            tbl[i].v    = (i < 12);
            tbl[i].r    = (i >= 10);
            tbl[i].cnt  = cnt_tab[i];
            tbl[i].crdy = !(i == 8 || i == 9);
        end

        do_reset();

        // 3-beat AFU packet, empty FIFO, 1-cycle latency.
        push_afu(1, 3);
        fork
            send_pkt(1, 3);
            begin
                @(negedge clk);
                chk("lat_before", 64'(tx_tvalid), 64'd0);
                @(negedge clk);
                chk("lat_after", 64'(tx_tvalid), 64'd1);
            end
        join
        wait_drain();

        // Completion arriving mid-packet follows the last beat.
        push_afu(2, 4);
        push_cpl(80);
        fork
            send_pkt(2, 4);
            begin
                repeat (2) @(posedge clk);
                #1;
                cpl_push(80);
            end
        join
        wait_drain();

        // FIFO fill / full / drain vectors.
        idx = 200;
        foreach (tbl[i]) begin
            cpl_valid = tbl[i].v;
            cpl_hdr   = mk_hdr(idx);
            tx_tready = tbl[i].r;
            @(negedge clk);
            acc = cpl_valid && cpl_ready;
            if (acc) push_cpl(idx);
            @(posedge clk);
            if (acc) idx++;
            #1;
            chk($sformatf("tbl_cnt[%0d]", i), 64'(cpl_fifo_cnt),
                64'(tbl[i].cnt));
            chk($sformatf("tbl_rdy[%0d]", i), 64'(cpl_ready),
                64'(tbl[i].crdy));
        end
        cpl_valid = 1'b0;
        tx_tready = 1'b1;
        chk("tbl_pushed", 64'(idx), 64'd210);
        wait_drain();

        // Burst of 2: CPL,CPL,AFU pkt,CPL,AFU pkt.
        do_reset();
        push_cpl(100);
        push_cpl(101);
        push_afu(3, 2);
        push_cpl(102);
        push_afu(4, 2);
        tx_tready = 1'b0;
        cpl_valid = 1'b1;
        cpl_hdr   = mk_hdr(100);
        @(posedge clk);
        #1;
        cpl_hdr    = mk_hdr(101);
        afu_tvalid = 1'b1;
        afu_tdata  = afu_d(3, 0);
        afu_tkeep  = afu_k(1'b0);
        afu_tuser  = TUW'(3);
        afu_tlast  = 1'b0;
        @(posedge clk);
        #1;
        cpl_hdr = mk_hdr(102);
        @(posedge clk);
        #1;
        cpl_valid = 1'b0;
        chk("burst_cnt", 64'(cpl_fifo_cnt), 64'd2);
        tx_tready = 1'b1;
        send_pkt(3, 2);
        send_pkt(4, 2);
        wait_drain();

        // Toggling backpressure with mixed traffic.
        push_afu(5, 3);
        push_cpl(110);
        push_cpl(111);
        push_afu(6, 2);
        tx_tready = 1'b1;
        fork
            begin
                send_pkt(5, 3);
                send_pkt(6, 2);
            end
            begin
                @(posedge clk);
                #1;
                cpl_push(110);
                cpl_push(111);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1;
                    tx_tready = !tx_tready;
                end
                tx_tready = 1'b1;
            end
        join
        wait_drain();

        // Statistics: 5 completions, peak occupancy 3.
        do_reset();
        for (int n = 120; n < 125; n++) push_cpl(n);
        tx_tready = 1'b0;
        cpl_valid = 1'b1;
        for (int n = 120; n < 124; n++) begin
            cpl_hdr = mk_hdr(n);
            @(posedge clk);
            #1;
        end
        cpl_valid = 1'b0;
        chk("stat_peak_cnt", 64'(cpl_fifo_cnt), 64'd3);
        tx_tready = 1'b1;
        cpl_push(124);
        wait_drain();
`ifdef OFS_FIM_ATS_TX_ARB_STATS_EN
        chk("stat_cpl_cnt", 64'(stat_cpl_cnt), 64'd5);
        chk("stat_fifo_hwm", 64'(stat_fifo_hwm), 64'd3);
`else
        chk("stat_cpl_cnt", 64'(stat_cpl_cnt), 64'd0);
        chk("stat_fifo_hwm", 64'(stat_fifo_hwm), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
